// File: rtl/ins_fetch.sv
// ins_fetch: RV32E fetch stage. Owns the PC, keeps one imem request outstanding and buffers words for the decoder.
// Optional macro FETCH_ERR_EN adds imem_err/ins_err and halts fetching after an erroring word until redirect.
module ins_fetch_chk (
    input logic clk,
    input logic rst_n,
    input logic in_req,
    input logic imem_rvalid
);
    // read data may only return for a request that has been granted
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n) !(in_req && imem_rvalid));
endmodule

module ins_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
`ifdef FETCH_ERR_EN
    input  logic        imem_err,
    output logic        ins_err,
`endif
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic        ins_valid,
    input  logic        ins_ready
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [31:0]   RESET_PC_C = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_RESP = 2'd1,
        S_DROP = 2'd2
    } state_e;

    state_e        state_r;
    logic [31:0]   fetch_pc_r;
    logic          drop_pend_r;
    logic [CW-1:0] count_r;
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [31:0]   mem_ins_r [FIFO_DEPTH];
    logic [31:0]   mem_pc_r  [FIFO_DEPTH];

    logic          push_s;
    logic          pop_s;
    logic          halt_nxt_s;
    logic          can_req_s;
    logic          in_req_s;
    logic [CW-1:0] count_nxt_s;
    logic [AW-1:0] rd_nxt_s;
    logic [31:0]   fetch_pc_nxt_s;
    logic [31:0]   head_ins_s;
    logic [31:0]   head_pc_s;

`ifdef FETCH_ERR_EN
    logic          halt_r;
    logic          mem_err_r [FIFO_DEPTH];
    logic          head_err_s;
`endif

    assign in_req_s = (state_r == S_REQ);
    assign push_s   = (state_r == S_RESP) && imem_rvalid && !redirect;
    assign pop_s    = ins_valid && ins_ready && !redirect;
    assign rd_nxt_s = pop_s ? (rd_ptr_r + AW'(1'b1)) : rd_ptr_r;

    // occupancy after this cycle's push/pop/flush
    always_comb begin
        count_nxt_s = count_r;
        if (redirect) begin
            count_nxt_s = {CW{1'b0}};
        end else if (push_s && !pop_s) begin
            count_nxt_s = count_r + CW'(1'b1);
        end else if (!push_s && pop_s) begin
            count_nxt_s = count_r - CW'(1'b1);
        end else begin
            count_nxt_s = count_r;
        end
    end

    // halt state after this cycle; a redirect always restarts fetching
    always_comb begin
        halt_nxt_s = 1'b0;
`ifdef FETCH_ERR_EN
        if (redirect) begin
            halt_nxt_s = 1'b0;
        end else begin
            halt_nxt_s = halt_r | (push_s & imem_err);
        end
`endif
    end

    assign can_req_s = (count_nxt_s < DEPTH_C) && !halt_nxt_s;

    // next fetch address; a grant of a request already doomed by redirect does not advance it
    always_comb begin
        fetch_pc_nxt_s = fetch_pc_r;
        if (redirect) begin
            fetch_pc_nxt_s = {redirect_pc[31:2], 2'b00};
        end else if (in_req_s && imem_req && imem_gnt && !drop_pend_r) begin
            fetch_pc_nxt_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_nxt_s = fetch_pc_r;
        end
    end

    // FIFO head after this edge, forwarding the word being written when it lands at the head slot
    always_comb begin
        head_ins_s = mem_ins_r[rd_nxt_s];
        head_pc_s  = mem_pc_r[rd_nxt_s];
`ifdef FETCH_ERR_EN
        head_err_s = mem_err_r[rd_nxt_s];
`endif
        if (push_s && (wr_ptr_r == rd_nxt_s)) begin
            head_ins_s = imem_rdata;
            head_pc_s  = imem_addr;
`ifdef FETCH_ERR_EN
            head_err_s = imem_err;
`endif
        end else begin
            head_ins_s = mem_ins_r[rd_nxt_s];
            head_pc_s  = mem_pc_r[rd_nxt_s];
`ifdef FETCH_ERR_EN
            head_err_s = mem_err_r[rd_nxt_s];
`endif
        end
    end

    // fetch FSM: request issue, response wait and drop of flushed responses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= S_REQ;
            imem_req    <= 1'b0;
            imem_addr   <= RESET_PC_C;
            fetch_pc_r  <= RESET_PC_C;
            drop_pend_r <= 1'b0;
`ifdef FETCH_ERR_EN
            halt_r      <= 1'b0;
`endif
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
`ifdef FETCH_ERR_EN
            halt_r     <= halt_nxt_s;
`endif
            case (state_r)
                S_REQ: begin
                    if (imem_req) begin
                        if (imem_gnt) begin
                            imem_req    <= 1'b0;
                            drop_pend_r <= 1'b0;
                            state_r     <= (redirect || drop_pend_r) ? S_DROP : S_RESP;
                        end else begin
                            drop_pend_r <= drop_pend_r | redirect;
                        end
                    end else begin
                        imem_req  <= can_req_s;
                        imem_addr <= fetch_pc_nxt_s;
                    end
                end
                S_RESP: begin
                    if (imem_rvalid) begin
                        state_r   <= S_REQ;
                        imem_req  <= can_req_s;
                        imem_addr <= fetch_pc_nxt_s;
                    end else if (redirect) begin
                        state_r <= S_DROP;
                    end else begin
                        state_r <= S_RESP;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_r   <= S_REQ;
                        imem_req  <= can_req_s;
                        imem_addr <= fetch_pc_nxt_s;
                    end else begin
                        state_r <= S_DROP;
                    end
                end
                default: begin
                    state_r     <= S_REQ;
                    imem_req    <= 1'b0;
                    drop_pend_r <= 1'b0;
                end
            endcase
        end
    end

    // instruction FIFO with registered head outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_ins_r[i] <= 32'h0;
                mem_pc_r[i]  <= 32'h0;
`ifdef FETCH_ERR_EN
                mem_err_r[i] <= 1'b0;
`endif
            end
            wr_ptr_r  <= {AW{1'b0}};
            rd_ptr_r  <= {AW{1'b0}};
            count_r   <= {CW{1'b0}};
            ins_valid <= 1'b0;
            ins       <= 32'h0;
            ins_pc    <= 32'h0;
`ifdef FETCH_ERR_EN
            ins_err   <= 1'b0;
`endif
        end else begin
            if (push_s) begin
                mem_ins_r[wr_ptr_r] <= imem_rdata;
                mem_pc_r[wr_ptr_r]  <= imem_addr;
`ifdef FETCH_ERR_EN
                mem_err_r[wr_ptr_r] <= imem_err;
`endif
            end
            if (redirect) begin
                wr_ptr_r <= {AW{1'b0}};
                rd_ptr_r <= {AW{1'b0}};
            end else begin
                wr_ptr_r <= push_s ? (wr_ptr_r + AW'(1'b1)) : wr_ptr_r;
                rd_ptr_r <= rd_nxt_s;
            end
            count_r   <= count_nxt_s;
            ins_valid <= (count_nxt_s != {CW{1'b0}});
            ins       <= head_ins_s;
            ins_pc    <= head_pc_s;
`ifdef FETCH_ERR_EN
            ins_err   <= head_err_s;
`endif
        end
    end

    ins_fetch_chk u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_req      (in_req_s),
        .imem_rvalid (imem_rvalid)
    );

endmodule

// File: doc/ins_fetch.md
Name: ins_fetch

Overview:
Instruction fetch stage for the RV32E core, directly upstream of the instruction decoder.
- Owns the PC and issues word reads to instruction memory over a req/gnt/rvalid handshake.
- Buffers returned words with their PCs in a small FIFO.
- Presents {ins, ins_pc} to the decoder with a valid/ready handshake.
- Supports a redirect (branch/jump target) that flushes all in-flight and buffered fetches.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request.
- imem_addr  out  32  word-aligned fetch address.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  read data valid; at least 1 cycle after the gnt cycle.
- imem_rdata  in  32  instruction word.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address.
- ins  out  32  instruction to decoder (FIFO head).
- ins_pc  out  32  PC of ins.
- ins_valid  out  1  head entry valid.
- ins_ready  in  1  decoder accepts head.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low. Reset values: imem_req=0, imem_addr=RESET_PC, ins_valid=0, ins=0, ins_pc=0, FIFO count=0, fetch_pc=RESET_PC, FSM=REQ.
- FSM states:
  - REQ: imem_req=1 when FIFO count < FIFO_DEPTH, else 0. On req&gnt, go to RESP and set fetch_pc += 4.
  - RESP: waits for imem_rvalid. On rvalid, push {imem_rdata, issued addr} into the FIFO and go to REQ.
  - DROP: waits for imem_rvalid and discards the data, then goes to REQ.
- Request rules:
  - At most one outstanding request.
  - imem_addr and imem_req stay stable from assertion until gnt; a request is never withdrawn.
  - imem_addr is a register holding the issued address.
- First request: imem_req is asserted in the first cycle after rst_n deasserts.
- Latency: gnt at cycle N, rvalid at N+k gives ins_valid at N+k+1 (FIFO write is registered).
  - The next imem_req may assert in cycle N+k+1.
  - Peak throughput: 1 instruction per 2 cycles with a 1-cycle memory.
- FIFO:
  - Pop on ins_valid & ins_ready.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - Full (count==FIFO_DEPTH) suppresses imem_req; data is never lost.
- PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC → 32'h0000_0000.
- Redirect (priority over everything else, effective the same cycle):
  - FIFO is cleared; ins_valid=0 from the next cycle.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - If in RESP, go to DROP.
  - If in REQ with req asserted but no gnt: the request is held. On its gnt go to DROP, and fetch_pc is not incremented.
  - If in REQ with gnt in the same cycle: go to DROP.
  - If already in DROP: stay in DROP.
  - Any ins handshake in the redirect cycle is void; the downstream stage flushes too.
  - The next request uses the redirected fetch_pc.
- Redirect and rvalid in the same cycle: the data is discarded and the FSM goes to REQ.
- Reset mid-transaction: all state returns to reset values immediately. A later stray rvalid while in REQ is ignored.
- Protocol error: rvalid while in REQ is ignored. A simulation-only assertion flags it.

Optional Feature:
Macro FETCH_ERR_EN.
- Defined:
  - Adds input imem_err (1, qualified by imem_rvalid) and output ins_err (1, accompanies the head entry; reset 0).
  - The erroring word is pushed with ins_err=1.
  - After it, fetching halts (FSM holds REQ with imem_req=0) until redirect.
- Undefined:
  - The ports are absent.
  - Fetch never halts on errors.

Test Plan:
- Reset and stream: RESET_PC=0; 1-cycle gnt and rvalid; ins_ready=1 → ins_pc sequence 0,4,8,… on alternate cycles; ins equals imem_rdata per address.
- Backpressure: ins_ready=0, FIFO_DEPTH=2 → two entries buffered (pc 0,4), then imem_req=0. Raising ins_ready pops pc 0 next, and req resumes at addr 8.
- Redirect with response outstanding: gnt for addr 8, redirect_pc=0x100 before rvalid → returned word dropped, ins_valid=0, next imem_addr=0x100, first delivered ins_pc=0x100.
- Redirect while request ungranted: req addr 0x10 held, gnt 3 cycles later, redirect_pc=0x203 → addr 0x10 stays stable until gnt, its data is dropped, next addr=0x200.
- Wrap-around: redirect_pc=32'hFFFF_FFFC → ins_pc 0xFFFF_FFFC then 0x0000_0000.
- FETCH_ERR_EN: imem_err=1 on the word at 0x8 → ins_err=1 with ins_pc=0x8, no further req. redirect 0x40 → fetch resumes at 0x40 and ins_err=0.
